// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state/owner types and address split constants for the SRAM arbiter.
package sram_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RECOVER} state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_t;
    localparam int BLOCK_SEL_MSB = 16;
    localparam int SRAM_BLK_AW = 15;
endpackage

// File: rtl/sram_block_enable.sv
// sram_block_enable: 2-bit block index plus enable to one-hot active-low chip enables.
module sram_block_enable (
    input  logic [1:0] i_idx,
    input  logic       i_en,
    output logic [3:0] o_block_l
);
    always_comb o_block_l = i_en ? ~(4'b0001 << i_idx) : 4'b1111;
endmodule

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares the 128K-word SRAM between the 68000 and a DMA requester,
// sequencing SETUP/ACCESS/HOLD/RECOVER with fully registered SRAM controls.
module sram_access_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset_L,
    input  logic [16:0] Address,
    input  logic        SRamSelect_H,
    input  logic        AS_L,
    input  logic        RW,
    input  logic        UDS_L,
    input  logic        LDS_L,
    input  logic [15:0] CpuWrData,
    input  logic        DmaReq_H,
    input  logic [16:0] DmaAddr,
    input  logic        DmaRW,
    input  logic [15:0] DmaWrData,
    output logic        DmaAck_H,
    output logic [15:0] DmaRdData,
    output logic        Dtack_L,
    output logic [14:0] SramAddr,
    output logic [3:0]  Block_L,
    output logic        OE_L,
    output logic        WE_L,
    output logic        UB_L,
    output logic        LB_L,
    output logic [15:0] SramWrData,
    output logic        SramDataOE_H,
    input  logic [15:0] SramRdData
);
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t      r_state, w_next;
    owner_t      r_owner, r_last, w_owner;
    logic [2:0]  r_cnt;
    logic        r_rw, r_ub, r_lb;
    logic [1:0]  r_blk, w_blk;
    logic        w_idle, w_cpu_req, w_dma_req, w_grant, w_grant_cpu, w_abort, w_busy;
    logic        w_rw, w_ub, w_lb, w_last_acc;
    logic [16:0] w_addr;
    logic [3:0]  w_block_l;

    // In IDLE the granted request is muxed straight from the inputs so SETUP strobes appear one edge after the grant.
    always_comb begin
        w_idle      = r_state == IDLE;
        w_cpu_req   = SRamSelect_H & ~AS_L;
        w_dma_req   = DmaReq_H;
        w_grant_cpu = w_cpu_req & (~w_dma_req | (r_last == OWN_DMA));
        w_grant     = w_idle & (w_cpu_req | w_dma_req);
        w_addr      = w_grant_cpu ? Address : DmaAddr;
        w_owner     = w_idle ? (w_grant_cpu ? OWN_CPU : OWN_DMA) : r_owner;
        w_rw        = w_idle ? (w_grant_cpu ? RW : DmaRW) : r_rw;
        w_ub        = w_idle ? (w_grant_cpu & UDS_L) : r_ub;
        w_lb        = w_idle ? (w_grant_cpu & LDS_L) : r_lb;
        w_blk       = w_idle ? w_addr[BLOCK_SEL_MSB -: 2] : r_blk;
        w_abort     = (r_owner == OWN_CPU) & AS_L;
        w_last_acc  = (r_state == ACCESS) & (r_cnt == 3'd0);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_cpu_req | w_dma_req) ? SETUP : IDLE;
            SETUP:   w_next = w_abort ? RECOVER : ACCESS;
            ACCESS:  w_next = w_abort ? RECOVER : (r_cnt == 3'd0 ? HOLD : ACCESS);
            HOLD:    w_next = (r_owner == OWN_DMA || AS_L) ? RECOVER : HOLD;
            RECOVER: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_busy = (w_next == SETUP) | (w_next == ACCESS) | (w_next == HOLD);
    end

    sram_block_enable u_blk (
        .i_idx     (w_blk),
        .i_en      (w_busy),
        .o_block_l (w_block_l)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_owner      <= OWN_DMA;
            r_last       <= OWN_DMA;
            r_rw         <= 1'b1;
            r_ub         <= 1'b1;
            r_lb         <= 1'b1;
            r_blk        <= 2'd0;
            SramAddr     <= '0;
            SramWrData   <= '0;
            DmaRdData    <= '0;
            Block_L      <= 4'b1111;
            OE_L         <= 1'b1;
            WE_L         <= 1'b1;
            UB_L         <= 1'b1;
            LB_L         <= 1'b1;
            SramDataOE_H <= 1'b0;
            Dtack_L      <= 1'b1;
            DmaAck_H     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == SETUP) ? WS : (r_state == ACCESS && r_cnt != 3'd0) ? r_cnt - 3'd1 : r_cnt;
            if (w_grant) begin
                r_owner    <= w_owner;
                r_last     <= w_owner;
                r_rw       <= w_rw;
                r_ub       <= w_ub;
                r_lb       <= w_lb;
                r_blk      <= w_blk;
                SramAddr   <= w_addr[SRAM_BLK_AW-1:0];
                SramWrData <= w_grant_cpu ? CpuWrData : DmaWrData;
            end
            if (w_last_acc && r_owner == OWN_DMA && r_rw)
                DmaRdData <= SramRdData;
            Block_L      <= w_block_l;
            OE_L         <= ~(w_rw & ((w_next == ACCESS) | ((w_next == HOLD) & (w_owner == OWN_CPU))));
            WE_L         <= ~(~w_rw & (w_next == ACCESS));
            UB_L         <= ~w_busy | w_ub;
            LB_L         <= ~w_busy | w_lb;
            SramDataOE_H <= w_busy & ~w_rw;
            Dtack_L      <= ~((w_next == HOLD) & (w_owner == OWN_CPU));
            DmaAck_H     <= (w_next == HOLD) & (w_owner == OWN_DMA);
        end
    end
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: directed checks of the SRAM arbiter at WAIT_STATES=2 and 7.
module tb_sram_access_arbiter;
    logic        Clk = 1'b0;
    logic        Reset_L, Reset7_L;
    logic [16:0] Address, DmaAddr;
    logic        SRamSelect_H, AS_L, RW, UDS_L, LDS_L, DmaReq_H, DmaReq7_H, DmaRW;
    logic [15:0] CpuWrData, DmaWrData, SramRdData;
    logic        DmaAck_H, Dtack_L, OE_L, WE_L, UB_L, LB_L, SramDataOE_H;
    logic [15:0] DmaRdData, SramWrData;
    logic [14:0] SramAddr;
    logic [3:0]  Block_L;
    logic        DmaAck7_H, Dtack7_L, OE7_L, WE7_L, UB7_L, LB7_L, SramDataOE7_H;
    logic [15:0] DmaRdData7, SramWrData7;
    logic [14:0] SramAddr7;
    logic [3:0]  Block7_L;
    int errors = 0;
    int checks = 0;

    localparam logic [10:0] IDLE_CTL = 11'b1_0_1111_1111_0;

    always #5 Clk = ~Clk;

    sram_access_arbiter #(.WAIT_STATES(2)) dut (
        .Clk(Clk), .Reset_L(Reset_L), .Address(Address), .SRamSelect_H(SRamSelect_H),
        .AS_L(AS_L), .RW(RW), .UDS_L(UDS_L), .LDS_L(LDS_L), .CpuWrData(CpuWrData),
        .DmaReq_H(DmaReq_H), .DmaAddr(DmaAddr), .DmaRW(DmaRW), .DmaWrData(DmaWrData),
        .DmaAck_H(DmaAck_H), .DmaRdData(DmaRdData), .Dtack_L(Dtack_L), .SramAddr(SramAddr),
        .Block_L(Block_L), .OE_L(OE_L), .WE_L(WE_L), .UB_L(UB_L), .LB_L(LB_L),
        .SramWrData(SramWrData), .SramDataOE_H(SramDataOE_H), .SramRdData(SramRdData)
    );

    sram_access_arbiter #(.WAIT_STATES(7)) dut7 (
        .Clk(Clk), .Reset_L(Reset7_L), .Address(Address), .SRamSelect_H(1'b0),
        .AS_L(1'b1), .RW(RW), .UDS_L(UDS_L), .LDS_L(LDS_L), .CpuWrData(CpuWrData),
        .DmaReq_H(DmaReq7_H), .DmaAddr(DmaAddr), .DmaRW(DmaRW), .DmaWrData(DmaWrData),
        .DmaAck_H(DmaAck7_H), .DmaRdData(DmaRdData7), .Dtack_L(Dtack7_L), .SramAddr(SramAddr7),
        .Block_L(Block7_L), .OE_L(OE7_L), .WE_L(WE7_L), .UB_L(UB7_L), .LB_L(LB7_L),
        .SramWrData(SramWrData7), .SramDataOE_H(SramDataOE7_H), .SramRdData(SramRdData)
    );

    function automatic logic [10:0] ctl(input logic d, input logic a, input logic [3:0] b,
                                        input logic oe, input logic we, input logic ub,
                                        input logic lb, input logic doe);
        return {d, a, b, oe, we, ub, lb, doe};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = {Dtack_L, DmaAck_H, Block_L, OE_L, WE_L, UB_L, LB_L, SramDataOE_H};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s {dtack,ack,blk,oe,we,ub,lb,doe} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl7(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = {Dtack7_L, DmaAck7_H, Block7_L, OE7_L, WE7_L, UB7_L, LB7_L, SramDataOE7_H};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s {dtack,ack,blk,oe,we,ub,lb,doe} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_L = 1'b0; Reset7_L = 1'b0;
        Address = '0; SRamSelect_H = 1'b0; AS_L = 1'b1; RW = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
        CpuWrData = '0; DmaReq_H = 1'b0; DmaReq7_H = 1'b0; DmaAddr = '0; DmaRW = 1'b1;
        DmaWrData = '0; SramRdData = '0;
        repeat (2) tick();
        chk_ctl("reset_ctl", IDLE_CTL);
        chk("reset_addr", 32'(SramAddr), 32'h0);
        chk("reset_wdata", 32'(SramWrData), 32'h0);
        chk("reset_rdata", 32'(DmaRdData), 32'h0);
        chk_ctl7("reset7_ctl", IDLE_CTL);
        Reset_L = 1'b1; Reset7_L = 1'b1;
        tick();
        chk_ctl("idle", IDLE_CTL);

        // CPU read of 0x1_2345
        Address = 17'h12345; RW = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0; SRamSelect_H = 1'b1; AS_L = 1'b0;
        tick();
        chk_ctl("rd_setup", ctl(1, 0, 4'b1011, 1, 1, 0, 0, 0));
        chk("rd_addr", 32'(SramAddr), 32'h2345);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("rd_access", ctl(1, 0, 4'b1011, 0, 1, 0, 0, 0));
        end
        tick();
        chk_ctl("rd_hold", ctl(0, 0, 4'b1011, 0, 1, 0, 0, 0));
        tick();
        chk_ctl("rd_hold2", ctl(0, 0, 4'b1011, 0, 1, 0, 0, 0));
        AS_L = 1'b1; SRamSelect_H = 1'b0;
        tick();
        chk_ctl("rd_recover", IDLE_CTL);
        tick();
        chk_ctl("rd_idle", IDLE_CTL);

        // DMA write 0x0_8000 <= 0xBEEF, request dropped early
        DmaReq_H = 1'b1; DmaAddr = 17'h08000; DmaRW = 1'b0; DmaWrData = 16'hBEEF;
        tick();
        DmaReq_H = 1'b0;
        chk_ctl("dw_setup", ctl(1, 0, 4'b1101, 1, 1, 0, 0, 1));
        chk("dw_addr", 32'(SramAddr), 32'h0);
        chk("dw_wdata", 32'(SramWrData), 32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("dw_access", ctl(1, 0, 4'b1101, 1, 0, 0, 0, 1));
        end
        tick();
        chk_ctl("dw_hold_ack", ctl(1, 1, 4'b1101, 1, 1, 0, 0, 1));
        tick();
        chk_ctl("dw_recover", IDLE_CTL);
        tick();
        chk_ctl("dw_idle", IDLE_CTL);

        // Tie after reset: CPU first, then DMA, then CPU again
        Reset_L = 1'b0;
        tick();
        Reset_L = 1'b1;
        Address = 17'h00010; RW = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0; SRamSelect_H = 1'b1; AS_L = 1'b0;
        DmaReq_H = 1'b1; DmaAddr = 17'h18000; DmaRW = 1'b1; SramRdData = 16'hCAFE;
        tick();
        chk_ctl("tie_cpu_setup", ctl(1, 0, 4'b1110, 1, 1, 0, 0, 0));
        chk("tie_cpu_addr", 32'(SramAddr), 32'h10);
        repeat (3) tick();
        tick();
        chk_ctl("tie_cpu_hold", ctl(0, 0, 4'b1110, 0, 1, 0, 0, 0));
        AS_L = 1'b1; SRamSelect_H = 1'b0;
        tick();
        chk_ctl("tie_recover", IDLE_CTL);
        tick();
        chk_ctl("tie_idle", IDLE_CTL);
        tick();
        chk_ctl("tie_dma_setup", ctl(1, 0, 4'b0111, 1, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("tie_dma_access", ctl(1, 0, 4'b0111, 0, 1, 0, 0, 0));
        end
        tick();
        chk_ctl("tie_dma_hold", ctl(1, 1, 4'b0111, 1, 1, 0, 0, 0));
        chk("tie_dma_rdata", 32'(DmaRdData), 32'hCAFE);
        DmaReq_H = 1'b0;
        tick();
        SRamSelect_H = 1'b1; AS_L = 1'b0; DmaReq_H = 1'b1;
        tick();
        chk_ctl("tie2_idle", IDLE_CTL);
        tick();
        chk_ctl("tie2_cpu_wins", ctl(1, 0, 4'b1110, 1, 1, 0, 0, 0));
        AS_L = 1'b1; SRamSelect_H = 1'b0; DmaReq_H = 1'b0;
        tick();
        chk_ctl("setup_abort", IDLE_CTL);
        tick();
        chk("rdata_held", 32'(DmaRdData), 32'hCAFE);

        // CPU upper-byte write
        Address = 17'h04000; RW = 1'b0; UDS_L = 1'b0; LDS_L = 1'b1; CpuWrData = 16'h1234;
        SRamSelect_H = 1'b1; AS_L = 1'b0;
        tick();
        chk_ctl("bw_setup", ctl(1, 0, 4'b1110, 1, 1, 0, 1, 1));
        chk("bw_addr", 32'(SramAddr), 32'h4000);
        chk("bw_wdata", 32'(SramWrData), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("bw_access", ctl(1, 0, 4'b1110, 1, 0, 0, 1, 1));
        end
        tick();
        chk_ctl("bw_hold", ctl(0, 0, 4'b1110, 1, 1, 0, 1, 1));
        AS_L = 1'b1; SRamSelect_H = 1'b0;
        tick();
        chk_ctl("bw_recover", IDLE_CTL);
        tick();

        // CPU write aborted during ACCESS
        Address = 17'h00100; RW = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0; CpuWrData = 16'h5555;
        SRamSelect_H = 1'b1; AS_L = 1'b0;
        tick();
        chk_ctl("ab_setup", ctl(1, 0, 4'b1110, 1, 1, 0, 0, 1));
        tick();
        chk_ctl("ab_access", ctl(1, 0, 4'b1110, 1, 0, 0, 0, 1));
        AS_L = 1'b1;
        tick();
        chk_ctl("ab_recover", IDLE_CTL);
        tick();
        chk_ctl("ab_idle", IDLE_CTL);
        SRamSelect_H = 1'b0;

        // WAIT_STATES=7: reset during DMA read ACCESS, then re-service
        DmaAddr = 17'h00042; DmaRW = 1'b1; SramRdData = 16'h5A5A; DmaReq7_H = 1'b1;
        tick();
        chk_ctl7("w7_setup", ctl(1, 0, 4'b1110, 1, 1, 0, 0, 0));
        chk("w7_addr", 32'(SramAddr7), 32'h42);
        repeat (2) tick();
        chk_ctl7("w7_access", ctl(1, 0, 4'b1110, 0, 1, 0, 0, 0));
        Reset7_L = 1'b0;
        tick();
        chk_ctl7("w7_reset", IDLE_CTL);
        chk("w7_reset_rdata", 32'(DmaRdData7), 32'h0);
        tick();
        chk_ctl7("w7_reset2", IDLE_CTL);
        Reset7_L = 1'b1;
        tick();
        chk_ctl7("w7_resetup", ctl(1, 0, 4'b1110, 1, 1, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_ctl7("w7_reaccess", ctl(1, 0, 4'b1110, 0, 1, 0, 0, 0));
        end
        tick();
        chk_ctl7("w7_ack", ctl(1, 1, 4'b1110, 1, 1, 0, 0, 0));
        chk("w7_rdata", 32'(DmaRdData7), 32'h5A5A);
        DmaReq7_H = 1'b0;
        tick();
        chk_ctl7("w7_recover", IDLE_CTL);
        chk_ctl("main_quiet", IDLE_CTL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
